aes_request_scheduler: RTL and testbench

Shares one fixed-latency, non-stalling AES encoder pipeline among `NUM_REQ` requesters. Each requester presents a `state_t` block and a `key_t` key with a valid/ready handshake. The scheduler grants one request per cycle round-robin and tracks every in-flight block with its requester ID. Results land in an output FIFO returned to a single consumer, and a credit counter keeps that FIFO from overflowing even though the AES pipeline cannot be stalled.

---
 rtl/aes_request_scheduler_pkg.sv | 15 +
 rtl/aes_request_scheduler_rr_arbiter.sv | 42 ++++
 rtl/aes_request_scheduler.sv | 106 ++++++++++
 tb/tb_aes_request_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_request_scheduler_pkg.sv
// Shared AES type definitions: block/key types and the in-flight tag carried
// alongside each block through the encoder pipeline.
package AESDefinitions;
  localparam int AES_STATE_SIZE  = 128;
  localparam int KEY_BYTES       = 16;
  localparam int MAX_REQ_ID_BITS = 4;

  typedef logic [AES_STATE_SIZE-1:0] state_t;
  typedef logic [KEY_BYTES*8-1:0]    key_t;

  typedef struct packed {
    logic                       valid;
    logic [MAX_REQ_ID_BITS-1:0] id;
  } aes_tag_t;
endpackage

// File: rtl/aes_request_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches from last_grant+1 and returns one-hot grant
// plus its encoded index. last_grant only moves when a grant is issued.
module aes_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_id
);
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [IDW-1:0] idx;

  // NOTE: every output gets a default before any branch, so no latch is inferred.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = '0;
    if (enable) begin
      // Walk from farthest to nearest so the nearest requester wins last.
      for (int i = NUM_REQ; i >= 1; i--) begin
        idx = IDW'((int'(last_grant_q) + i) % NUM_REQ);
        if (req[idx]) begin
          grant      = '0;
          grant[idx] = 1'b1;
          grant_id   = idx;
        end
      end
    end
  end

  assign last_grant_d = (|grant) ? grant_id : last_grant_q;

  // NOTE: clocked state uses non-blocking assignment; combinational logic uses blocking.
  always_ff @(posedge clock) begin
    if (reset) last_grant_q <= IDW'(NUM_REQ - 1);
    else       last_grant_q <= last_grant_d;
  end
endmodule

// File: rtl/aes_request_scheduler.sv
// Shares one fixed-latency, non-stallable AES pipeline among NUM_REQ requesters;
// a credit counter bounds in-flight plus queued blocks to the output FIFO depth.
module aes_request_scheduler
  import AESDefinitions::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int PIPE_LATENCY = 10,
  parameter  int OUT_DEPTH    = 12,
  localparam int IDW          = $clog2(NUM_REQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  state_t [NUM_REQ-1:0] req_data,
  input  key_t [NUM_REQ-1:0]   req_key,
  output state_t               aes_data_in,
  output key_t                 aes_key_in,
  input  state_t               aes_data_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output state_t               rsp_data,
  output logic [IDW-1:0]       rsp_id
);
  localparam int CNTW = $clog2(OUT_DEPTH + 1);
  localparam int PTRW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  logic [NUM_REQ-1:0]         grant;
  logic [IDW-1:0]             grant_id;
  logic                       issue_ok, issue, push, pop;
  logic [CNTW-1:0]            cnt_q, cnt_d;
  logic [CNTW-1:0]            fill_q;
  logic [PTRW-1:0]            wr_ptr_q, rd_ptr_q;
  state_t                     data_q;
  key_t                       key_q;
  aes_tag_t                   tag_q [PIPE_LATENCY+1];
  state_t                     fifo_data_q [OUT_DEPTH];
  logic [MAX_REQ_ID_BITS-1:0] fifo_id_q [OUT_DEPTH];

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(OUT_DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  // A pop frees its credit only from the following cycle onwards.
  assign issue_ok = !reset && (cnt_q < CNTW'(OUT_DEPTH));

  aes_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clock    (clock),
    .reset    (reset),
    .req      (req_valid),
    .enable   (issue_ok),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready   = grant;
  assign issue       = |grant;
  assign push        = tag_q[PIPE_LATENCY].valid;
  assign rsp_valid   = !reset && (fill_q != '0);
  assign pop         = rsp_valid && rsp_ready;
  assign rsp_data    = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign rsp_id      = rsp_valid ? IDW'(fifo_id_q[rd_ptr_q]) : '0;
  assign aes_data_in = reset ? '0 : data_q;
  assign aes_key_in  = reset ? '0 : key_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({issue, pop})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      fill_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      data_q   <= '0;
      key_q    <= '0;
      for (int i = 0; i <= PIPE_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (issue) begin
        data_q <= req_data[grant_id];
        key_q  <= req_key[grant_id];
      end
      tag_q[0] <= '{valid: issue, id: MAX_REQ_ID_BITS'(grant_id)};
      for (int i = 1; i <= PIPE_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      fill_q <= fill_q + CNTW'(1);
      else if (pop && !push) fill_q <= fill_q - CNTW'(1);
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and fill count decide what is valid.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      fifo_data_q[wr_ptr_q] <= aes_data_out;
      fifo_id_q[wr_ptr_q]   <= tag_q[PIPE_LATENCY].id;
    end
  end
endmodule

// File: tb/tb_aes_request_scheduler.sv
// Self-checking bench: AES-128 encoder model drives aes_data_out; a queue-based
// reference model predicts grants, credits and responses every cycle.
module tb_aes_request_scheduler;
  import AESDefinitions::*;

  localparam int NUM_REQ      = 4;
  localparam int PIPE_LATENCY = 10;
  localparam int OUT_DEPTH    = 12;
  localparam int IDW          = $clog2(NUM_REQ);

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_ready;
  state_t [NUM_REQ-1:0] req_data = '0;
  key_t [NUM_REQ-1:0]   req_key = '0;
  state_t               aes_data_in, aes_data_out;
  key_t                 aes_key_in;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  state_t               rsp_data;
  logic [IDW-1:0]       rsp_id;

  always #5 clock = ~clock;

  aes_request_scheduler #(
    .NUM_REQ(NUM_REQ), .PIPE_LATENCY(PIPE_LATENCY), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_key(req_key), .aes_data_in(aes_data_in),
    .aes_key_in(aes_key_in), .aes_data_out(aes_data_out), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, r1, r2, r3, r4;
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        repeat (254) inv = gmul(inv, 8'(x));
      end
      r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
      sbox[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    end
  end

  function automatic state_t aes_encrypt(input state_t pt, input key_t key);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  rcon, a0, a1, a2, a3;
    logic [31:0] tmp;
    state_t      ct;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp  = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[c*4+row] = t[((c+row)%4)*4+row];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    return ct;
  endfunction

  // Fixed-latency encoder: result of an operand appears PIPE_LATENCY cycles later.
  state_t enc_pipe [PIPE_LATENCY];
  always @(posedge clock) begin
    enc_pipe[0] <= aes_encrypt(aes_data_in, aes_key_in);
    for (int i = 1; i < PIPE_LATENCY; i++) enc_pipe[i] <= enc_pipe[i-1];
  end
  assign aes_data_out = enc_pipe[PIPE_LATENCY-1];

  // ---------------- reference model + compare ----------------
  typedef struct { int cyc; int id; state_t data; } ev_t;
  typedef struct { int vis; int id; state_t ct; } exp_t;
  ev_t  issue_log [$];
  ev_t  rsp_log [$];
  exp_t mq [$];
  int   cyc = 0;
  int   m_cnt = 0;
  int   m_last = NUM_REQ - 1;
  state_t m_ain = '0;
  key_t   m_kin = '0;
  logic [NUM_REQ-1:0] e_ready;
  logic e_valid;
  int   g;
  ev_t  ev;
  exp_t ex;

  always @(negedge clock) begin
    cyc++;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_valid[i] && req_ready[i]) begin
        ev = '{cyc, i, req_data[i]};
        issue_log.push_back(ev);
      end
    if (rsp_valid && rsp_ready) begin
      ev = '{cyc, int'(rsp_id), rsp_data};
      rsp_log.push_back(ev);
    end
    if (reset) begin
      check("reset_req_ready", req_ready, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_data", rsp_data, 0);
      check("reset_rsp_id", rsp_id, 0);
      check("reset_aes_data_in", aes_data_in, 0);
      check("reset_aes_key_in", aes_key_in, 0);
      mq.delete();
      m_cnt = 0; m_last = NUM_REQ - 1; m_ain = '0; m_kin = '0;
    end else begin
      e_valid = (mq.size() > 0) && (mq[0].vis <= cyc);
      e_ready = '0;
      g = -1;
      if (m_cnt < OUT_DEPTH)
        for (int k = 1; k <= NUM_REQ; k++)
          if (g < 0 && req_valid[(m_last + k) % NUM_REQ]) g = (m_last + k) % NUM_REQ;
      if (g >= 0) e_ready[g] = 1'b1;
      check("req_ready", req_ready, e_ready);
      check("rsp_valid", rsp_valid, e_valid);
      if (e_valid) begin
        check("rsp_data", rsp_data, mq[0].ct);
        check("rsp_id", rsp_id, mq[0].id);
      end
      check("aes_data_in", aes_data_in, m_ain);
      check("aes_key_in", aes_key_in, m_kin);
      if (e_valid && rsp_ready) begin
        void'(mq.pop_front());
        m_cnt--;
      end
      if (g >= 0) begin
        ex = '{cyc + 2 + PIPE_LATENCY, g, aes_encrypt(req_data[g], req_key[g])};
        mq.push_back(ex);
        m_cnt++; m_last = g; m_ain = req_data[g]; m_kin = req_key[g];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [NUM_REQ-1:0] mask, input logic rdy);
    req_valid = mask;
    rsp_ready = rdy;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[i] = {$urandom, $urandom, $urandom, $urandom};
      req_key[i]  = {$urandom, $urandom, $urandom, $urandom};
    end
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    tick();
    tick();
    reset = 1'b0;
    issue_log.delete();
    rsp_log.delete();
  endtask

  initial begin
    tick();
    check("fips_model", aes_encrypt(128'h00112233445566778899aabbccddeeff,
                                    128'h000102030405060708090a0b0c0d0e0f),
          128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // FIPS-197 single block from requester 0
    do_reset();
    req_data[0] = 128'h00112233445566778899aabbccddeeff;
    req_key[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    repeat (PIPE_LATENCY + 6) tick();
    check("fips_issue_count", issue_log.size(), 1);
    check("fips_rsp_count", rsp_log.size(), 1);
    if (issue_log.size() == 1 && rsp_log.size() == 1) begin
      check("fips_issue_id", issue_log[0].id, 0);
      check("fips_latency", rsp_log[0].cyc - issue_log[0].cyc, PIPE_LATENCY + 2);
      check("fips_ct", rsp_log[0].data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      check("fips_rsp_id", rsp_log[0].id, 0);
    end

    // Round-robin fairness with all requesters valid
    do_reset();
    repeat (16) drive(4'hf, 1'b1);
    repeat (25) drive(4'h0, 1'b1);
    check("rr_enough_issues", issue_log.size() >= 8, 1);
    for (int i = 0; i < 8 && i < issue_log.size(); i++) check("rr_grant_order", issue_log[i].id, i % 4);
    for (int i = 0; i < 8 && i < rsp_log.size(); i++) check("rr_rsp_order", rsp_log[i].id, i % 4);
    check("rr_all_returned", rsp_log.size(), issue_log.size());

    // Credit backpressure
    do_reset();
    repeat (30) drive(4'hf, 1'b0);
    check("bp_issue_count", issue_log.size(), OUT_DEPTH);
    drive(4'hf, 1'b1);
    repeat (5) drive(4'hf, 1'b0);
    check("bp_issue_after_pop", issue_log.size(), OUT_DEPTH + 1);
    check("bp_single_pop", rsp_log.size(), 1);
    if (issue_log.size() == OUT_DEPTH + 1 && rsp_log.size() == 1)
      check("bp_issue_cycle", issue_log[OUT_DEPTH].cyc, rsp_log[0].cyc + 1);
    repeat (40) drive(4'h0, 1'b1);

    // Full-throughput random mix, 100 blocks
    do_reset();
    for (int k = 0; k < 400 && issue_log.size() < 100; k++) drive(4'($urandom_range(1, 15)), 1'b1);
    repeat (30) drive(4'h0, 1'b1);
    check("tp_issue_count", issue_log.size(), 100);
    check("tp_rsp_count", rsp_log.size(), 100);
    for (int i = 0; i < 100 && i < rsp_log.size() && i < issue_log.size(); i++)
      check("tp_rsp_id_order", rsp_log[i].id, issue_log[i].id);

    // Reset while 5 blocks are in flight and 3 sit in the FIFO
    do_reset();
    repeat (8) drive(4'hf, 1'b0);
    repeat (6) drive(4'h0, 1'b0);
    check("mid_pre_reset_rsp_valid", rsp_valid, 1);
    reset = 1'b1;
    req_valid = '0;
    tick();
    reset = 1'b0;
    issue_log.delete();
    rsp_log.delete();
    repeat (30) drive(4'hf, 1'b1);
    repeat (30) drive(4'h0, 1'b1);
    check("mid_first_grant_nonempty", issue_log.size() > 0, 1);
    if (issue_log.size() > 0) check("mid_first_grant", issue_log[0].id, 0);
    check("mid_no_stale", rsp_log.size(), issue_log.size());

    // Sparse: only requester 2
    do_reset();
    repeat (20) drive(4'b0100, 1'b1);
    repeat (20) drive(4'h0, 1'b1);
    check("sparse_nonempty", rsp_log.size() > 0, 1);
    for (int i = 0; i < issue_log.size(); i++) check("sparse_grant_id", issue_log[i].id, 2);
    for (int i = 0; i < rsp_log.size(); i++) check("sparse_rsp_id", rsp_log[i].id, 2);

    // Random traffic with random consumer stalls and one mid-run reset
    do_reset();
    for (int k = 0; k < 400; k++) begin
      reset = (k == 200);
      drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    reset = 1'b0;
    repeat (40) drive(4'h0, 1'b1);
    check("rand_drained", rsp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
